// File: rtl/game_ctrl_if.sv
// Bus between the game sequencer and its surroundings: detector/input pulses in,
// game state, physics gating and BCD scores out.
interface game_ctrl_if;
  logic        frame_i;
  logic        flap_i;
  logic        collide_i;
  logic        oob_i;
  logic        point_i;
  logic [1:0]  state_o;
  logic        run_o;
  logic        world_rst_o;
  logic        flap_o;
  logic        blink_o;
  logic [15:0] score_o;
  logic [15:0] hiscore_o;
  logic        new_high_o;

  // Driver side: frame timing, debounced flap and detector levels.
  modport master (
    output frame_i, flap_i, collide_i, oob_i, point_i,
    input  state_o, run_o, world_rst_o, flap_o, blink_o,
           score_o, hiscore_o, new_high_o
  );

  // Sequencer side.
  modport slave (
    input  frame_i, flap_i, collide_i, oob_i, point_i,
    output state_o, run_o, world_rst_o, flap_o, blink_o,
           score_o, hiscore_o, new_high_o
  );
endinterface

// File: rtl/game_ctrl.sv
// Flappy-bird game sequencer: IDLE/PLAY/DYING/OVER state machine, physics gating,
// world reset, flap forwarding, and BCD running score / high score.
module game_ctrl #(
  parameter int unsigned DIE_FRAMES   = 60,
  parameter int unsigned OVER_FRAMES  = 120,
  parameter int unsigned BLINK_FRAMES = 8
) (
  input logic         clk,
  input logic         arst_i,
  game_ctrl_if.slave  bus
);

  localparam int unsigned CNT_W   = 8;
  localparam int unsigned SCORE_W = 16;

  localparam logic [CNT_W-1:0]   DIE_CNT   = CNT_W'(DIE_FRAMES);
  localparam logic [CNT_W-1:0]   OVER_CNT  = CNT_W'(OVER_FRAMES);
  localparam logic [CNT_W-1:0]   BLINK_CNT = CNT_W'(BLINK_FRAMES);
  localparam logic [SCORE_W-1:0] SCORE_MAX = 16'h9999;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    DYING = 2'd2,
    OVER  = 2'd3
  } state_t;

  state_t             state;
  logic               run;
  logic               world_rst;
  logic               flap_q;
  logic               blink;
  logic [SCORE_W-1:0] score;
  logic [SCORE_W-1:0] hiscore;
  logic               new_high;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   blink_cnt;
  logic [CNT_W-1:0]   cnt_inc;
  logic [CNT_W-1:0]   blink_inc;

  // Four-digit BCD increment, holding at 9999.
  function automatic logic [SCORE_W-1:0] bcd_inc(input logic [SCORE_W-1:0] v);
    logic [SCORE_W-1:0] r;
    logic               carry;
    r     = v;
    carry = 1'b1;
    if (v != SCORE_MAX) begin
      for (int i = 0; i < 4; i++) begin
        if (carry) begin
          if (r[i*4 +: 4] == 4'd9) begin
            r[i*4 +: 4] = 4'd0;
          end else begin
            r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
            carry       = 1'b0;
          end
        end
      end
    end
    return r;
  endfunction

  assign cnt_inc   = CNT_W'(cnt + CNT_W'(1));
  assign blink_inc = CNT_W'(blink_cnt + CNT_W'(1));

  // Game state machine; all outputs are registered alongside the state.
  always_ff @(posedge clk or posedge arst_i) begin
    if (arst_i) begin
      state     <= IDLE;
      run       <= 1'b0;
      world_rst <= 1'b1;
      flap_q    <= 1'b0;
      blink     <= 1'b0;
      score     <= '0;
      hiscore   <= '0;
      new_high  <= 1'b0;
      cnt       <= '0;
      blink_cnt <= '0;
    end else begin
      flap_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.flap_i) begin
            state     <= PLAY;
            run       <= 1'b1;
            world_rst <= 1'b0;
            flap_q    <= 1'b1;
            score     <= '0;
            new_high  <= 1'b0;
          end
        end
        PLAY: begin
          if (bus.flap_i) begin
            flap_q <= 1'b1;
          end
          // A hit in the same cycle as a point drops the point.
          if (bus.collide_i || bus.oob_i) begin
            state     <= DYING;
            run       <= 1'b0;
            cnt       <= '0;
            blink_cnt <= '0;
            blink     <= 1'b1;
          end else if (bus.point_i) begin
            score <= bcd_inc(score);
          end
        end
        DYING: begin
          if (bus.frame_i) begin
            if (cnt_inc == DIE_CNT) begin
              state     <= OVER;
              cnt       <= '0;
              blink     <= 1'b0;
              blink_cnt <= '0;
              // Plain unsigned compare orders BCD words correctly.
              if (score > hiscore) begin
                hiscore  <= score;
                new_high <= 1'b1;
              end
            end else begin
              cnt <= cnt_inc;
              if (blink_inc == BLINK_CNT) begin
                blink     <= ~blink;
                blink_cnt <= '0;
              end else begin
                blink_cnt <= blink_inc;
              end
            end
          end
        end
        OVER: begin
          if (bus.flap_i && (cnt == OVER_CNT)) begin
            state     <= IDLE;
            world_rst <= 1'b1;
            cnt       <= '0;
          end else if (bus.frame_i && (cnt != OVER_CNT)) begin
            cnt <= cnt_inc;
          end
        end
        default: begin
          state     <= IDLE;
          run       <= 1'b0;
          world_rst <= 1'b1;
        end
      endcase
    end
  end

  assign bus.state_o     = state;
  assign bus.run_o       = run;
  assign bus.world_rst_o = world_rst;
  assign bus.flap_o      = flap_q;
  assign bus.blink_o     = blink;
  assign bus.score_o     = score;
  assign bus.hiscore_o   = hiscore;
  assign bus.new_high_o  = new_high;

endmodule

// File: tb/tb_game_ctrl.sv
// Bench for game_ctrl: decimal-integer game model checked every cycle, plus
// hand-computed literal checkpoints along a scripted multi-round game.
module tb_game_ctrl;

  localparam int DIE = 4;
  localparam int OVR = 3;
  localparam int BLK = 2;

  logic clk;
  logic arst;

  int n_checks;
  int n_fail;

  game_ctrl_if bus ();

  game_ctrl #(
    .DIE_FRAMES   (DIE),
    .OVER_FRAMES  (OVR),
    .BLINK_FRAMES (BLK)
  ) dut (
    .clk    (clk),
    .arst_i (arst),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: scores are kept as ordinary decimal integers.
  int m_state;
  int m_score;
  int m_hi;
  int m_nh;
  int m_flap;
  int m_dframes;
  int m_oframes;

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model update from the inputs sampled at each clock edge.
  always @(posedge clk or posedge arst) begin
    if (arst) begin
      m_state = 0; m_score = 0; m_hi = 0; m_nh = 0;
      m_flap = 0; m_dframes = 0; m_oframes = 0;
    end else begin
      m_flap = 0;
      case (m_state)
        0: if (bus.flap_i) begin
             m_state = 1; m_score = 0; m_nh = 0; m_flap = 1;
           end
        1: begin
             if (bus.flap_i) m_flap = 1;
             if (bus.collide_i || bus.oob_i) begin
               m_state = 2; m_dframes = 0;
             end else if (bus.point_i && m_score < 9999) begin
               m_score = m_score + 1;
             end
           end
        2: if (bus.frame_i) begin
             m_dframes = m_dframes + 1;
             if (m_dframes == DIE) begin
               m_state = 3; m_oframes = 0;
               if (m_score > m_hi) begin
                 m_hi = m_score; m_nh = 1;
               end
             end
           end
        default: begin
             if (bus.flap_i && m_oframes == OVR) m_state = 0;
             else if (bus.frame_i && m_oframes < OVR) m_oframes = m_oframes + 1;
           end
      endcase
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    chk("state", 32'(bus.state_o), 32'(m_state));
    chk("run", 32'(bus.run_o), 32'(m_state == 1));
    chk("world_rst", 32'(bus.world_rst_o), 32'(m_state == 0));
    chk("flap_o", 32'(bus.flap_o), 32'(m_flap));
    chk("blink", 32'(bus.blink_o),
        32'((m_state == 2) && (((m_dframes / BLK) % 2) == 0)));
    chk("score", 32'(bus.score_o), 32'(to_bcd(m_score)));
    chk("hiscore", 32'(bus.hiscore_o), 32'(to_bcd(m_hi)));
    chk("new_high", 32'(bus.new_high_o), 32'(m_nh));
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic pulse_flap();
    bus.flap_i = 1'b1;
    step();
    bus.flap_i = 1'b0;
  endtask

  task automatic points(input int n);
    bus.point_i = 1'b1;
    repeat (n) step();
    bus.point_i = 1'b0;
  endtask

  task automatic frames(input int n);
    repeat (n) begin
      bus.frame_i = 1'b1;
      step();
      bus.frame_i = 1'b0;
      step();
    end
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    arst = 1'b1;
    bus.frame_i = 1'b0; bus.flap_i = 1'b0; bus.collide_i = 1'b0;
    bus.oob_i = 1'b0; bus.point_i = 1'b0;
    repeat (2) step();
    arst = 1'b0;
    neg();
    chk("rst_state", 32'(bus.state_o), 32'd0);
    chk("rst_world_rst", 32'(bus.world_rst_o), 32'd1);
    chk("rst_score", 32'(bus.score_o), 32'h0);

    // Round A: start, BCD carry, saturation, then reset mid-PLAY.
    pulse_flap();
    neg();
    chk("start_state", 32'(bus.state_o), 32'd1);
    chk("start_flap", 32'(bus.flap_o), 32'd1);
    chk("start_run", 32'(bus.run_o), 32'd1);
    chk("start_world_rst", 32'(bus.world_rst_o), 32'd0);
    step();
    neg();
    chk("flap_one_cycle", 32'(bus.flap_o), 32'd0);
    points(10);
    neg();
    chk("score_10", 32'(bus.score_o), 32'h0010);
    points(3);
    neg();
    chk("score_13", 32'(bus.score_o), 32'h0013);
    points(9985);
    neg();
    chk("score_9998", 32'(bus.score_o), 32'h9998);
    points(3);
    neg();
    chk("score_sat", 32'(bus.score_o), 32'h9999);
    pulse_flap();
    neg();
    chk("play_flap", 32'(bus.flap_o), 32'd1);
    #1 arst = 1'b1;
    #1;
    chk("arstA_state", 32'(bus.state_o), 32'd0);
    chk("arstA_score", 32'(bus.score_o), 32'h0);
    step();
    arst = 1'b0;

    // Round B: hit wins over point, dying blink, new high score.
    pulse_flap();
    points(5);
    bus.collide_i = 1'b1; bus.point_i = 1'b1;
    step();
    bus.collide_i = 1'b0; bus.point_i = 1'b0;
    neg();
    chk("hit_state", 32'(bus.state_o), 32'd2);
    chk("hit_score", 32'(bus.score_o), 32'h0005);
    chk("hit_run", 32'(bus.run_o), 32'd0);
    chk("hit_blink", 32'(bus.blink_o), 32'd1);
    frames(1);
    neg();
    chk("blink_f1", 32'(bus.blink_o), 32'd1);
    frames(1);
    neg();
    chk("blink_f2", 32'(bus.blink_o), 32'd0);
    frames(1);
    neg();
    chk("dying_f3", 32'(bus.state_o), 32'd2);
    frames(1);
    neg();
    chk("over_state", 32'(bus.state_o), 32'd3);
    chk("over_hi", 32'(bus.hiscore_o), 32'h0005);
    chk("over_nh", 32'(bus.new_high_o), 32'd1);
    frames(2);
    pulse_flap();
    neg();
    chk("over_early_flap", 32'(bus.state_o), 32'd3);
    frames(1);
    pulse_flap();
    neg();
    chk("over_to_idle", 32'(bus.state_o), 32'd0);
    chk("idle_world_rst", 32'(bus.world_rst_o), 32'd1);
    pulse_flap();
    neg();
    chk("replay_state", 32'(bus.state_o), 32'd1);
    chk("replay_score", 32'(bus.score_o), 32'h0);

    // Round C: lower score keeps the high score.
    points(3);
    bus.oob_i = 1'b1;
    step();
    bus.oob_i = 1'b0;
    frames(4);
    neg();
    chk("c_state", 32'(bus.state_o), 32'd3);
    chk("c_hi", 32'(bus.hiscore_o), 32'h0005);
    chk("c_nh", 32'(bus.new_high_o), 32'd0);
    frames(3);
    pulse_flap();

    // Round D: high score 0100, then reset mid-PLAY at 0042.
    pulse_flap();
    points(100);
    neg();
    chk("d_score", 32'(bus.score_o), 32'h0100);
    bus.collide_i = 1'b1;
    step();
    bus.collide_i = 1'b0;
    frames(4);
    neg();
    chk("d_hi", 32'(bus.hiscore_o), 32'h0100);
    frames(3);
    pulse_flap();
    pulse_flap();
    points(42);
    neg();
    chk("d_score42", 32'(bus.score_o), 32'h0042);
    #1 arst = 1'b1;
    #1;
    chk("arst_state", 32'(bus.state_o), 32'd0);
    chk("arst_score", 32'(bus.score_o), 32'h0);
    chk("arst_hi", 32'(bus.hiscore_o), 32'h0);
    chk("arst_flap", 32'(bus.flap_o), 32'd0);
    chk("arst_run", 32'(bus.run_o), 32'd0);
    step();
    arst = 1'b0;
    repeat (3) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
